// File: rtl/bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : bus_interconnect
// Purpose  : N-master / M-slave single-transaction bus interconnect with
//            round-robin arbitration, base/mask address decode and
//            error termination of unmapped or hung accesses.
// Revision : 1.0 - initial release
// ============================================================================
module bus_interconnect #(
  parameter int                       NUM_MASTERS = 2,
  parameter int                       NUM_SLAVES  = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE  = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK  = {NUM_SLAVES{32'hFFFFFFFF}},
  parameter int                       TIMEOUT     = 1023
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_MASTERS-1:0]    i_m_request,
  input  logic [NUM_MASTERS-1:0]    i_m_rw,
  input  logic [NUM_MASTERS*32-1:0] i_m_address,
  input  logic [NUM_MASTERS*32-1:0] i_m_wdata,
  output logic [NUM_MASTERS-1:0]    o_m_ready,
  output logic [NUM_MASTERS*32-1:0] o_m_rdata,
  output logic [NUM_MASTERS-1:0]    o_m_error,
  output logic [NUM_SLAVES-1:0]     o_s_request,
  output logic                      o_s_rw,
  output logic [31:0]               o_s_address,
  output logic [31:0]               o_s_wdata,
  input  logic [NUM_SLAVES*32-1:0]  i_s_rdata,
  input  logic [NUM_SLAVES-1:0]     i_s_ready
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] c_TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [MW-1:0] c_LAST_RST = MW'(NUM_MASTERS - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [MW-1:0] r_last;      // last granted master, also owner of current transaction
  logic [SW-1:0] r_sel;
  logic          r_rw;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_m_rdata [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] r_m_error;

  logic [31:0]   w_m_addr  [NUM_MASTERS];
  logic [31:0]   w_m_wdata [NUM_MASTERS];
  logic [31:0]   w_s_rdata [NUM_SLAVES];
  logic [31:0]   w_base    [NUM_SLAVES];
  logic [31:0]   w_mask    [NUM_SLAVES];

  logic          w_any;
  logic [MW-1:0] w_gnt;
  logic [31:0]   w_req_addr;
  logic          w_hit;
  logic [SW-1:0] w_sel;
  logic [31:0]   w_offset;
  logic          w_s_ready;
  logic          w_timeout;

  // Unpack per-master buses and drive the per-master result slices.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign w_m_addr[gi]               = i_m_address[gi*32 +: 32];
      assign w_m_wdata[gi]              = i_m_wdata[gi*32 +: 32];
      assign o_m_rdata[gi*32 +: 32]     = r_m_rdata[gi];
    end
    for (genvar gs = 0; gs < NUM_SLAVES; gs++) begin : g_slave
      assign w_s_rdata[gs] = i_s_rdata[gs*32 +: 32];
      assign w_base[gs]    = SLAVE_BASE[gs*32 +: 32];
      assign w_mask[gs]    = SLAVE_MASK[gs*32 +: 32];
    end
  endgenerate

  assign w_any      = |i_m_request;
  assign w_req_addr = w_m_addr[w_gnt];
  assign w_offset   = w_req_addr & ~w_mask[w_sel];
  assign w_s_ready  = i_s_ready[r_sel];
  assign w_timeout  = (r_cnt == c_TO_LAST);

  assign o_s_rw      = r_rw;
  assign o_s_address = r_addr;
  assign o_s_wdata   = r_wdata;
  assign o_m_error   = r_m_error;

  // Round-robin pick: scan farthest-first so the nearest requester after r_last wins.
  always_comb begin
    w_gnt = r_last;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      if (i_m_request[(int'(r_last) + i) % NUM_MASTERS]) begin
        w_gnt = MW'((int'(r_last) + i) % NUM_MASTERS);
      end
    end
  end

  // Address decode: scan high-to-low so the lowest matching slave index wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((w_req_addr & w_mask[i]) == (w_base[i] & w_mask[i])) begin
        w_hit = 1'b1;
        w_sel = SW'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= c_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (w_any) w_next = w_hit ? c_ACCESS : c_DONE;
      c_ACCESS: if (w_s_ready || w_timeout) w_next = c_DONE;
      c_DONE:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; reset clears them without waiting for a clock.
  always_comb begin
    o_s_request = '0;
    o_m_ready   = '0;
    if (r_state == c_ACCESS) o_s_request[r_sel] = 1'b1;
    if (r_state == c_DONE)   o_m_ready[r_last]  = 1'b1;
  end

  // Transaction latches, wait counter and per-master response registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_last    <= c_LAST_RST;
      r_sel     <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_m_error <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_m_rdata[i] <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_last  <= w_gnt;
            r_sel   <= w_sel;
            r_rw    <= i_m_rw[w_gnt];
            r_addr  <= w_hit ? w_offset : 32'h0;
            r_wdata <= w_m_wdata[w_gnt];
            r_cnt   <= '0;
            if (!w_hit) begin
              r_m_rdata[w_gnt] <= '0;
              r_m_error[w_gnt] <= 1'b1;
            end
          end
        end
        c_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_s_ready) begin
            // Writes return zero so stale slave data never leaks to the master.
            r_m_rdata[r_last] <= r_rw ? 32'h0 : w_s_rdata[r_sel];
            r_m_error[r_last] <= 1'b0;
          end else if (w_timeout) begin
            r_m_rdata[r_last] <= '0;
            r_m_error[r_last] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_interconnect
// Purpose  : Self-checking bench for bus_interconnect with per-master
//            expected-response queues and a behavioural slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_interconnect;

  localparam int NM = 2;
  localparam int NS = 8;
  localparam int TO = 8;

  localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h5000_0000, 32'h2000_0000,
                                        32'h3000_0000, 32'h5000_0000, 32'h6000_0000, 32'h8000_0000};
  localparam logic [31:0] MASK [NS] = '{32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                        32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [NS*32-1:0] P_BASE = {32'h8000_0000, 32'h6000_0000, 32'h5000_0000, 32'h3000_0000,
                                         32'h2000_0000, 32'h5000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] P_MASK = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000,
                                         32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_rw;
  logic [NM*32-1:0]  m_addr, m_wdata;
  logic [NM-1:0]     o_m_ready, o_m_error;
  logic [NM*32-1:0]  o_m_rdata;
  logic [NS-1:0]     o_s_request;
  logic              o_s_rw;
  logic [31:0]       o_s_address, o_s_wdata;
  logic [NS*32-1:0]  s_rdata;
  logic [NS-1:0]     s_ready;

  int n_chk = 0;
  int n_err = 0;
  logic [32:0] exp_q [NM][$];
  int          order_q [$];
  int          scnt [NS];
  logic [32:0] mon_e;

  bus_interconnect #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_BASE(P_BASE), .SLAVE_MASK(P_MASK), .TIMEOUT(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_m_request(m_req), .i_m_rw(m_rw), .i_m_address(m_addr), .i_m_wdata(m_wdata),
    .o_m_ready(o_m_ready), .o_m_rdata(o_m_rdata), .o_m_error(o_m_error),
    .o_s_request(o_s_request), .o_s_rw(o_s_rw), .o_s_address(o_s_address), .o_s_wdata(o_s_wdata),
    .i_s_rdata(s_rdata), .i_s_ready(s_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int decode(input logic [31:0] a);
    for (int s = 0; s < NS; s++)
      if ((a & MASK[s]) == (BASE[s] & MASK[s])) return s;
    return -1;
  endfunction

  function automatic int delay_of(input int s);
    return (s == 6) ? 100000 : s % 4;   // slave 6 never answers
  endfunction

  function automatic logic [31:0] slave_rd(input int s, input logic [31:0] off);
    return {4'(s), 28'h0} ^ off ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] wfn(input logic [31:0] off);
    return off ^ 32'hC0DE_F00D;
  endfunction

  function automatic logic [32:0] model(input bit rw, input logic [31:0] a);
    int s = decode(a);
    if (s < 0 || s == 6) return {1'b1, 32'h0};
    if (rw) return {1'b0, 32'h0};
    return {1'b0, slave_rd(s, a & ~MASK[s])};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [3:0] nibs [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h5, 4'h6, 4'h7};
    int k = $urandom_range(0, 9);
    logic [3:0] n;
    if (k == 0) return {16'h0000, 16'($urandom)};
    if (k == 1) return {16'h0001, 16'($urandom)};
    n = nibs[$urandom_range(0, 7)];
    if (n == 4'h5 && $urandom_range(0, 1) == 1) return {16'h5000, 16'($urandom)};
    return {n, 28'($urandom)};
  endfunction

  // ---------------- slave model ----------------
  always @(negedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (o_s_request[s]) begin
        if (scnt[s] == 0) begin
          check("s_onehot", 64'($onehot(o_s_request)), 64'd1);
          if (o_s_rw) check("s_wdata", o_s_wdata, wfn(o_s_address));
        end
        s_ready[s] = (scnt[s] == delay_of(s));
        s_rdata[s*32 +: 32] = slave_rd(s, o_s_address);
        scnt[s]++;
      end else begin
        scnt[s] = 0;
        s_ready[s] = 1'($urandom_range(0, 1));
        s_rdata[s*32 +: 32] = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (o_m_ready != '0) check("m_ready_onehot", 64'($onehot(o_m_ready)), 64'd1);
      for (int m = 0; m < NM; m++) begin
        if (o_m_ready[m]) begin
          if (exp_q[m].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_ready: master %0d got a completion, required none", m);
          end else begin
            mon_e = exp_q[m].pop_front();
            check("m_rdata", o_m_rdata[m*32 +: 32], mon_e[31:0]);
            check("m_error", o_m_error[m], mon_e[32]);
            order_q.push_back(m);
          end
        end
      end
    end
  end

  // ---------------- master drivers ----------------
  task automatic start(input int m, input bit rw, input logic [31:0] a);
    int s = decode(a);
    logic [31:0] off = (s >= 0) ? (a & ~MASK[s]) : a;
    exp_q[m].push_back(model(rw, a));
    m_req[m] = 1'b1;
    m_rw[m]  = rw;
    m_addr[m*32 +: 32]  = a;
    m_wdata[m*32 +: 32] = wfn(off);
  endtask

  task automatic wait_ready(input int m, input bit hold, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (o_m_ready[m]) break;
      if (lat >= 200) begin
        n_chk++;
        n_err++;
        $display("FAIL ready_wait: master %0d got no ready in %0d cycles, required a pulse", m, lat);
        break;
      end
    end
    if (!hold) m_req[m] = 1'b0;
  endtask

  task automatic timed(input int m, input bit rw, input logic [31:0] a, input int lat,
                       input logic [NS-1:0] sreq, input logic [31:0] off);
    start(m, rw, a);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check("t_ready_low", o_m_ready, 64'd0);
        check("t_sreq", o_s_request, sreq);
        check("t_saddr", o_s_address, off);
        check("t_srw", o_s_rw, rw);
      end else begin
        check("t_ready", o_m_ready, 64'(1 << m));
        check("t_sreq_done", o_s_request, 64'd0);
      end
    end
    m_req[m] = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    int gap = $urandom_range(0, 2);
    int ngap;
    int lat;
    for (int i = 0; i < n; i++) begin
      repeat (gap) @(negedge clk);
      ngap = (i == n - 1) ? 1 : $urandom_range(0, 2);
      start(m, 1'($urandom_range(0, 1)), rand_addr());
      wait_ready(m, ngap == 0, lat);
      gap = ngap;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int l0, l1;
    rst = 1'b1;
    m_req = '0; m_rw = '0; m_addr = '0; m_wdata = '0;
    s_ready = '0; s_rdata = '0;
    for (int s = 0; s < NS; s++) scnt[s] = 0;
    repeat (2) @(negedge clk);
    check("rst_m_ready", o_m_ready, 64'd0);
    check("rst_s_request", o_s_request, 64'd0);
    check("rst_m_rdata", o_m_rdata, 64'd0);
    check("rst_m_error", o_m_error, 64'd0);
    check("rst_s_address", o_s_address, 64'd0);
    check("rst_s_wdata", o_s_wdata, 64'd0);
    check("rst_s_rw", o_s_rw, 64'd0);
    rst = 1'b0;

    // Simultaneous requests, masters hold request into the next transaction.
    fork
      begin start(0, 1'b0, 32'h0000_0100); wait_ready(0, 1'b1, l0);
            start(0, 1'b0, 32'h1000_0020); wait_ready(0, 1'b0, l0); end
      begin start(1, 1'b0, 32'h0000_0200); wait_ready(1, 1'b1, l1);
            start(1, 1'b1, 32'h3000_0040); wait_ready(1, 1'b0, l1); end
    join
    @(negedge clk);
    check("rr_count", order_q.size(), 64'd4);
    if (order_q.size() == 4)
      for (int i = 0; i < 4; i++) check("rr_order", order_q[i], 64'(i % 2));
    order_q.delete();

    timed(0, 1'b0, 32'h0000_0010, 2, 8'h01, 32'h0000_0010);     // mapped, minimum latency
    @(negedge clk);
    timed(0, 1'b0, 32'h7000_0000, 1, 8'h00, 32'h0);             // unmapped
    @(negedge clk);
    timed(1, 1'b0, 32'h6000_0000, TO + 1, 8'h40, 32'h0);        // timeout
    @(negedge clk);
    timed(1, 1'b1, 32'h5000_0010, 4, 8'h04, 32'h0000_0010);     // overlap, write
    @(negedge clk);

    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    repeat (3) @(negedge clk);

    // Reset while a transaction is stuck in ACCESS.
    m_req[0] = 1'b1; m_rw[0] = 1'b0; m_addr[31:0] = 32'h6000_0000;
    repeat (3) @(negedge clk);
    check("pre_rst_sreq", o_s_request, 64'h40);
    #2 rst = 1'b1;
    #1 check("rst_async_sreq", o_s_request, 64'd0);
    check("rst_async_ready", o_m_ready, 64'd0);
    m_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    order_q.delete();
    start(1, 1'b0, 32'h2000_0004);
    start(0, 1'b0, 32'h0000_0008);
    fork
      wait_ready(0, 1'b0, l0);
      wait_ready(1, 1'b0, l1);
    join
    repeat (3) @(negedge clk);
    check("post_rst_count", order_q.size(), 64'd2);
    if (order_q.size() > 0) check("post_rst_first", order_q[0], 64'd0);
    for (int m = 0; m < NM; m++) check("exp_q_empty", exp_q[m].size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_interconnect.md
# bus_interconnect

Parametrised N-master / M-slave single-transaction bus interconnect. It replaces the fixed two-port CPU bus access plus hand-written address decode and ready/rdata muxing in the SoC top. It arbitrates masters round-robin, decodes the address against per-slave base/mask pairs, and forwards the transaction to one slave. It terminates unmapped or hung accesses with an error response.

## Interface
- NUM_MASTERS, 2, number of masters (1..8); index width MW = max(1,$clog2(NUM_MASTERS))
- NUM_SLAVES, 8, number of slaves (1..16)
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed NUM_SLAVES*32; slice i = base of slave i
- SLAVE_MASK, {NUM_SLAVES{32'hFFFFFFFF}}, packed; slice i = bits compared for slave i
- TIMEOUT, 1023, max cycles waiting for slave ready (>=1)

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_m_request  in  NUM_MASTERS  per-master request, held until o_m_ready
- i_m_rw  in  NUM_MASTERS  1 = write, 0 = read
- i_m_address  in  NUM_MASTERS*32  per-master byte address
- i_m_wdata  in  NUM_MASTERS*32  per-master write data
- o_m_ready  out  NUM_MASTERS  one-cycle completion pulse
- o_m_rdata  out  NUM_MASTERS*32  read data, valid with o_m_ready
- o_m_error  out  NUM_MASTERS  error flag, valid with o_m_ready
- o_s_request  out  NUM_SLAVES  one-hot slave request
- o_s_rw  out  1  shared rw to slaves
- o_s_address  out  32  shared slave offset = address & ~SLAVE_MASK[sel]
- o_s_wdata  out  32  shared write data
- i_s_rdata  in  NUM_SLAVES*32  per-slave read data
- i_s_ready  in  NUM_SLAVES  per-slave ready

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any i_m_request is set, grant the first requester in order last+1, last+2, … (mod NUM_MASTERS).
  - Latch master index, rw, address, wdata.
  - Decode: slave i matches when (address & MASK[i]) == (BASE[i] & MASK[i]); on overlap the lowest index wins.
  - Match → ACCESS. No match → DONE with error=1, rdata=0.
  - Update last = granted index.
- ACCESS: o_s_request[sel]=1. o_s_rw, o_s_address and o_s_wdata are driven from latches, stable for the whole state. Wait counter increments each cycle.
  - i_s_ready[sel]=1 → capture i_s_rdata[sel] (forced to 0 for writes), error=0 → DONE.
  - Counter reaches TIMEOUT with no ready → rdata=0, error=1 → DONE.
  - i_s_ready of unselected slaves is ignored.
- DONE: o_m_ready[granted]=1 for exactly one cycle, with registered o_m_rdata/o_m_error on that master's slice. Then → IDLE.
- Master rule: in the cycle after o_m_ready, the master either drops i_m_request or presents a new transaction. A request still high is treated as a new transaction.
- Master inputs outside IDLE are ignored. The latch isolates the slave from master changes mid-transaction.
- o_m_rdata/o_m_error slices hold their last value until the next completion for that master.

## Timing
- Reset (async, immediate): state=IDLE, last=NUM_MASTERS-1 (master 0 wins first). All o_m_ready, o_m_error, o_s_request, o_s_rw = 0. o_m_rdata, o_s_address, o_s_wdata = 0. Wait counter = 0.
- Reset mid-transaction: the slave request drops the same instant. No ready pulse is produced. The aborted transaction is lost.
- Mapped access: request sampled at edge 0 → o_s_request high from cycle 1. Slave ready in cycle k → o_s_request low and o_m_ready high in cycle k+1 → IDLE in cycle k+2. Minimum latency is 2 cycles (ready in cycle 1 → o_m_ready in cycle 2).
- Unmapped access: o_m_ready in cycle 1, error=1. No slave is touched.
- Timeout: with o_s_request high from cycle 1 and no ready, o_m_ready with error=1 in cycle TIMEOUT+1.
- Idle gap: back-to-back transactions have one IDLE cycle between DONE and the next ACCESS.
- Simultaneous requests: strict round-robin. With all masters requesting continuously, each is served once per NUM_MASTERS transactions.

## Test plan
- NM=2, slave0 base 0x0 mask 0xFFFF0000; m0 reads 0x00000010, slave ready in cycle 1 with 0x12345678 → o_s_address=0x10; o_m_ready[0] in cycle 2, rdata 0x12345678, error 0.
- Both masters request at once, repeatedly, 4 transactions → grant order m0, m1, m0, m1. No double grant when a master holds its request one cycle past ready.
- Access to 0x70000000 with no matching slave → o_m_ready at cycle 1, error=1, rdata=0, no o_s_request.
- TIMEOUT=8, slave never ready → o_s_request high for cycles 1..8; o_m_ready with error=1 at cycle 9.
- Overlapping slaves 2 and 5 both matching 0x50000010 → only o_s_request[2] is asserted. A write returns rdata=0.
- i_reset asserted in ACCESS → o_s_request=0 immediately, no o_m_ready. After release, m0 wins arbitration first.
